// File: rtl/interfaz_alu_if.sv
// Handshake and data signals between the serial link, the ALU and interfaz_alu.
interface interfaz_alu_if #(
   parameter int unsigned nbits = 8
);
   logic             rx_done;
   logic [nbits-1:0] rx_data;
   logic             tx_done;
   logic [nbits-1:0] alu_R;
   logic [nbits-1:0] alu_A;
   logic [nbits-1:0] alu_B;
   logic [5:0]       alu_Op;
   logic             tx_start;
   logic [nbits-1:0] tx_data;
   logic             busy;

   // Environment side: drives received bytes, tx completion and the ALU result.
   modport master (
      output rx_done, rx_data, tx_done, alu_R,
      input  alu_A, alu_B, alu_Op, tx_start, tx_data, busy
   );

   // interfaz_alu side.
   modport slave (
      input  rx_done, rx_data, tx_done, alu_R,
      output alu_A, alu_B, alu_Op, tx_start, tx_data, busy
   );
endinterface

// File: rtl/interfaz_alu.sv
// Collects operand A, operand B and an op code from a byte stream, lets the
// ALU settle for one cycle and hands the result to the transmitter.
module interfaz_alu #(
   parameter int unsigned nbits = 8
) (
   input logic           clk,
   input logic           reset,
   interfaz_alu_if.slave bus
);

   typedef enum logic [2:0] {
      ESPERA_A  = 3'd0,
      ESPERA_B  = 3'd1,
      ESPERA_OP = 3'd2,
      ENVIO     = 3'd3,
      ESPERA_TX = 3'd4
   } estado_t;

   estado_t          estado;
   logic [nbits-1:0] reg_a;
   logic [nbits-1:0] reg_b;
   logic [5:0]       reg_op;
   logic [nbits-1:0] reg_tx_data;
   logic             reg_tx_start;
   logic             reg_busy;

   // Sequencer: operand capture, one settle cycle, then wait for the transmitter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado       <= ESPERA_A;
         reg_a        <= '0;
         reg_b        <= '0;
         reg_op       <= '0;
         reg_tx_data  <= '0;
         reg_tx_start <= 1'b0;
         reg_busy     <= 1'b0;
      end else begin
         reg_tx_start <= 1'b0;
         case (estado)
            ESPERA_A: begin
               if (bus.rx_done) begin
                  reg_a  <= bus.rx_data;
                  estado <= ESPERA_B;
               end
            end
            ESPERA_B: begin
               if (bus.rx_done) begin
                  reg_b  <= bus.rx_data;
                  estado <= ESPERA_OP;
               end
            end
            ESPERA_OP: begin
               if (bus.rx_done) begin
                  reg_op   <= bus.rx_data[5:0];
                  reg_busy <= 1'b1;
                  estado   <= ENVIO;
               end
            end
            ENVIO: begin
               // ALU result is stable after one cycle with the new operands.
               reg_tx_data  <= bus.alu_R;
               reg_tx_start <= 1'b1;
               estado       <= ESPERA_TX;
            end
            ESPERA_TX: begin
               // Any byte arriving here (even with tx_done) is dropped.
               if (bus.tx_done) begin
                  reg_busy <= 1'b0;
                  estado   <= ESPERA_A;
               end
            end
            default: begin
               reg_busy <= 1'b0;
               estado   <= ESPERA_A;
            end
         endcase
      end
   end

   assign bus.alu_A    = reg_a;
   assign bus.alu_B    = reg_b;
   assign bus.alu_Op   = reg_op;
   assign bus.tx_data  = reg_tx_data;
   assign bus.tx_start = reg_tx_start;
   assign bus.busy     = reg_busy;

endmodule

// File: tb/tb_interfaz_alu.sv
// Directed bench for interfaz_alu with a behavioural 8-bit ALU attached.
module tb_interfaz_alu;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   pulses;

   interfaz_alu_if #(.nbits(8)) bus ();

   interfaz_alu #(.nbits(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU (standard MIPS-style op codes).
   always_comb begin
      case (bus.alu_Op)
         6'h20:   bus.alu_R = bus.alu_A + bus.alu_B;
         6'h22:   bus.alu_R = bus.alu_A - bus.alu_B;
         6'h24:   bus.alu_R = bus.alu_A & bus.alu_B;
         6'h25:   bus.alu_R = bus.alu_A | bus.alu_B;
         6'h26:   bus.alu_R = bus.alu_A ^ bus.alu_B;
         6'h27:   bus.alu_R = ~(bus.alu_A | bus.alu_B);
         6'h03:   bus.alu_R = 8'($signed(bus.alu_A) >>> bus.alu_B);
         6'h02:   bus.alu_R = bus.alu_A >> bus.alu_B;
         default: bus.alu_R = 8'h00;
      endcase
   end

   // Count cycles in which tx_start is high.
   always @(posedge clk) begin
      if (bus.tx_start === 1'b1) pulses++;
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [5:0] exp_op;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      @(posedge clk); #1;
      bus.rx_done = 1'b1;
      bus.rx_data = d;
      @(posedge clk); #1;
      bus.rx_done = 1'b0;
   endtask

   // Sends three bytes and checks the result pulse timing and value.
   task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp_data);
      int p0;
      p0 = pulses;
      send_byte(a);
      chk("busy_after_a", 32'(bus.busy), 32'd0);
      send_byte(b);
      send_byte(op);
      // One edge after the op byte: ENVIO, no pulse yet.
      chk("busy_envio", 32'(bus.busy), 32'd1);
      chk("tx_start_envio", 32'(bus.tx_start), 32'd0);
      @(posedge clk); #1;
      chk("tx_start_pulse", 32'(bus.tx_start), 32'd1);
      chk("tx_data", 32'(bus.tx_data), 32'(exp_data));
      @(posedge clk); #1;
      chk("tx_start_low", 32'(bus.tx_start), 32'd0);
      chk("busy_wait_tx", 32'(bus.busy), 32'd1);
      chk("pulse_count", 32'(pulses - p0), 32'd1);
   endtask

   task automatic finish_txn(input logic [7:0] exp_data);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_hold", 32'(bus.busy), 32'd1);
      bus.tx_done = 1'b1;
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
      chk("busy_done", 32'(bus.busy), 32'd0);
      chk("tx_data_held", 32'(bus.tx_data), 32'(exp_data));
   endtask

   initial begin
      int p0;
      checks   = 0;
      failures = 0;
      pulses   = 0;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.tx_done = 1'b0;

      vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp_op: 6'h20, exp_data: 8'h08}; // ADD
      vecs[1] = '{a: 8'h03, b: 8'h05, op: 8'h22, exp_op: 6'h22, exp_data: 8'hFE}; // SUB -2
      vecs[2] = '{a: 8'h0F, b: 8'h01, op: 8'hE0, exp_op: 6'h20, exp_data: 8'h10}; // op masked
      vecs[3] = '{a: 8'hF0, b: 8'h3C, op: 8'h24, exp_op: 6'h24, exp_data: 8'h30}; // AND
      vecs[4] = '{a: 8'h12, b: 8'h34, op: 8'h3F, exp_op: 6'h3F, exp_data: 8'h00}; // undefined

      // Reset held: everything zero regardless of clock.
      reset = 1'b1;
      #2;
      chk("rst_alu_A", 32'(bus.alu_A), 32'd0);
      chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_alu_Op", 32'(bus.alu_Op), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         start_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_data);
         chk("alu_Op", 32'(bus.alu_Op), 32'(vecs[i].exp_op));
         finish_txn(vecs[i].exp_data);
         chk("alu_A_held", 32'(bus.alu_A), 32'(vecs[i].a));
         chk("alu_B_held", 32'(bus.alu_B), 32'(vecs[i].b));
      end

      // Byte arriving while waiting for the transmitter is dropped.
      start_txn(8'h09, 8'h04, 8'h20, 8'h0D);
      send_byte(8'h77);
      chk("drop_alu_A", 32'(bus.alu_A), 32'h09);
      chk("drop_alu_B", 32'(bus.alu_B), 32'h04);
      chk("drop_alu_Op", 32'(bus.alu_Op), 32'h20);
      finish_txn(8'h0D);
      start_txn(8'h01, 8'h02, 8'h25, 8'h03);
      chk("or_alu_A", 32'(bus.alu_A), 32'h01);
      finish_txn(8'h03);

      // rx_done and tx_done together in ESPERA_TX: leave, drop the byte.
      start_txn(8'h06, 8'h02, 8'h22, 8'h04);
      p0 = pulses;
      @(posedge clk); #1;
      bus.rx_done = 1'b1;
      bus.rx_data = 8'h55;
      bus.tx_done = 1'b1;
      @(posedge clk); #1;
      bus.rx_done = 1'b0;
      bus.tx_done = 1'b0;
      chk("sim_busy", 32'(bus.busy), 32'd0);
      chk("sim_alu_A", 32'(bus.alu_A), 32'h06);
      repeat (3) @(posedge clk);
      #1;
      chk("sim_no_pulse", 32'(pulses - p0), 32'd0);
      start_txn(8'h0A, 8'h01, 8'h20, 8'h0B);
      chk("sim_next_A", 32'(bus.alu_A), 32'h0A);
      finish_txn(8'h0B);

      // Asynchronous reset mid-transaction, between clock edges.
      send_byte(8'h10);
      send_byte(8'h20);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_alu_A", 32'(bus.alu_A), 32'd0);
      chk("arst_alu_B", 32'(bus.alu_B), 32'd0);
      chk("arst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      p0 = pulses;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("arst_no_pulse", 32'(pulses - p0), 32'd0);
      chk("arst_tx_start", 32'(bus.tx_start), 32'd0);
      start_txn(8'h02, 8'h02, 8'h20, 8'h04);
      chk("arst_first_A", 32'(bus.alu_A), 32'h02);
      finish_txn(8'h04);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interfaz_alu.md
INTERFAZ_ALU -- requirements
Module: interfaz_alu

Interface
REQ-001 The block SHALL have parameter nbits, default 8, giving the operand/result/byte width; nbits SHALL be at least 6.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_done  input  1  one-cycle strobe; rx_data valid this cycle.
- rx_data  input  nbits  received byte.
- tx_done  input  1  one-cycle strobe; transmitter finished the current byte.
- alu_R  input  nbits  signed combinational result from the ALU.
- alu_A  output  nbits  registered signed operand A to the ALU.
- alu_B  output  nbits  registered signed operand B to the ALU.
- alu_Op  output  6  registered ALU operation code.
- tx_start  output  1  one-cycle request to transmit tx_data.
- tx_data  output  nbits  registered result byte for the transmitter.
- busy  output  1  high while a result is pending or being sent.

Function
REQ-003 The block SHALL implement a state machine with states ESPERA_A, ESPERA_B, ESPERA_OP, ENVIO and ESPERA_TX.
REQ-004 ESPERA_A: on rx_done, the block SHALL latch alu_A <= rx_data and go to ESPERA_B; otherwise it SHALL hold.
REQ-005 ESPERA_B: on rx_done, the block SHALL latch alu_B <= rx_data and go to ESPERA_OP.
REQ-006 ESPERA_OP: on rx_done, the block SHALL latch alu_Op <= rx_data[5:0], discard the upper bits, and go to ENVIO.
REQ-007 ENVIO SHALL last exactly one cycle so the ALU settles; at its exit edge the block SHALL set tx_data <= alu_R and tx_start <= 1, then go to ESPERA_TX.
REQ-008 tx_start SHALL be high for exactly one clock cycle per result and SHALL be low in every other cycle.
REQ-009 Latency: tx_start SHALL be high during the second cycle after the edge that samples the op byte, i.e. two edges after the op strobe.
REQ-010 ESPERA_TX: on tx_done, the block SHALL go to ESPERA_A; otherwise it SHALL hold.
REQ-011 busy SHALL be 1 exactly while in ENVIO or ESPERA_TX, and 0 otherwise.
REQ-012 In ENVIO or ESPERA_TX, rx_done SHALL be ignored and the byte dropped; alu_A, alu_B and alu_Op SHALL stay unchanged.
REQ-013 tx_done seen in any state other than ESPERA_TX SHALL be ignored.
REQ-014 If rx_done and tx_done occur in the same cycle in ESPERA_TX, the block SHALL go to ESPERA_A and discard the byte.
REQ-015 alu_A, alu_B and alu_Op SHALL hold their values until the same field is overwritten in the next transaction.
- The ALU sees stable operands between transactions.
REQ-016 Op codes SHALL be passed through unchecked.
- An undefined code transmits whatever alu_R is; for the standard ALU this is 0.
REQ-017 tx_data SHALL change only at the ENVIO exit edge or on reset.

Reset
REQ-018 While reset is high, the block SHALL be in ESPERA_A, and alu_A, alu_B, alu_Op, tx_data, tx_start and busy SHALL all be 0, regardless of clk.
REQ-019 Reset mid-transaction, in any state, SHALL abandon partial operands, with no tx_start pulse afterwards.
REQ-020 After reset deasserts, the first rx_done SHALL be taken as operand A.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADD: bytes 0x05, 0x03, 0x20 with 8-bit ALU attached -> one tx_start pulse, 2 edges after op, tx_data=0x08, busy 1 until tx_done.
- SUB signed: bytes 0x03, 0x05, 0x22 -> tx_data=0xFE (-2); after tx_done, state ESPERA_A, busy=0, alu_A=0x03 held.
- Op masking: bytes 0x0F, 0x01, 0xE0 -> alu_Op=0x20, tx_data=0x10.
- Dropped byte: rx_done 0x77 while in ESPERA_TX -> alu_A/B/Op unchanged; next transaction 0x01, 0x02, 0x25 -> tx_data=0x03 (OR).
- Simultaneous strobes: rx_done and tx_done in the same cycle in ESPERA_TX -> ESPERA_A, alu_A unchanged, no extra tx_start.
- Reset mid-op: after A=0x10 and B=0x20, assert reset asynchronously between edges -> all outputs 0 immediately, no tx_start; then 0x02, 0x02, 0x20 -> tx_data=0x04.
